// File: rtl/queue_pkg.sv
// Shared helpers for stream_queue: count width, wrapping pointer increment, status word.
package queue_pkg;

  function automatic int cnt_w(input int ptbits);
    return ptbits + 1;
  endfunction

  // Increment modulo 2**ptbits; callers cast the result back to their pointer width.
  function automatic logic [31:0] ptr_inc(input logic [31:0] p, input int ptbits);
    return (p + 32'd1) & ((32'd1 << ptbits) - 32'd1);
  endfunction

  typedef struct packed {
    logic em;
    logic full;
    logic almost_full;
    logic almost_empty;
    logic ovf;
    logic udf;
  } queue_status;

endpackage

// File: rtl/stream_queue_if.sv
// Producer/consumer bus of stream_queue: data, push/pop, flush and status.
interface stream_queue_if #(
  parameter int PTBITS = 6,
  parameter int NBITS  = 8
);
  logic              clr;
  logic [NBITS-1:0]  in;
  logic              ld;
  logic              pp;
  logic [NBITS-1:0]  out;
  logic              em;
  logic              full;
  logic              almost_full;
  logic              almost_empty;
  logic [PTBITS:0]   count;
  logic              ovf;
  logic              udf;
  logic [PTBITS:0]   peak;

  modport master (
    output clr, in, ld, pp,
    input  out, em, full, almost_full, almost_empty, count, ovf, udf, peak
  );

  modport slave (
    input  clr, in, ld, pp,
    output out, em, full, almost_full, almost_empty, count, ovf, udf, peak
  );
endinterface

// File: rtl/queue_ram.sv
// DEPTH x NBITS simple dual-port storage: synchronous write, asynchronous read.
module queue_ram #(
  parameter int PTBITS = 6,
  parameter int NBITS  = 8
) (
  input  logic              ck,
  input  logic              we,
  input  logic [PTBITS-1:0] wa,
  input  logic [NBITS-1:0]  wd,
  input  logic [PTBITS-1:0] ra,
  output logic [NBITS-1:0]  rd
);
  logic [NBITS-1:0] mem [0:(1<<PTBITS)-1];

  always_ff @(posedge ck)
    if (we) mem[wa] <= wd;

  assign rd = mem[ra];
endmodule

// File: rtl/stream_queue.sv
// Show-ahead single-clock queue with level flags, occupancy and sticky errors.
// Optional peak-occupancy register enabled by defining QUEUE_PEAK_EN.
module stream_queue
  import queue_pkg::*;
#(
  parameter int PTBITS   = 6,
  parameter int NBITS    = 8,
  parameter int AF_LEVEL = 48,
  parameter int AE_LEVEL = 8
) (
  input  logic ck,
  input  logic rst_n,
  stream_queue_if.slave q
);
  localparam int DEPTH = 1 << PTBITS;
  localparam int CW    = cnt_w(PTBITS);
  localparam logic [CW-1:0] FULL_C = CW'(DEPTH);
  localparam logic [CW-1:0] AF_C   = CW'(AF_LEVEL);
  localparam logic [CW-1:0] AE_C   = CW'(AE_LEVEL);

  logic [PTBITS-1:0] rd_pt, wr_pt;
  logic [CW-1:0]     cnt, cnt_nxt;
  logic              ovf_r, udf_r;
  logic              push_ok, pop_ok;
  queue_status       st;

  // Flags come straight from the registered count, so they settle the cycle after an edge.
  always_comb begin
    st              = '0;
    st.em           = (cnt == '0);
    st.full         = (cnt == FULL_C);
    st.almost_full  = (cnt >= AF_C);
    st.almost_empty = (cnt <= AE_C);
    st.ovf          = ovf_r;
    st.udf          = udf_r;
  end

  assign push_ok = q.ld & ~st.full;
  assign pop_ok  = q.pp & ~st.em;

  always_comb begin
    cnt_nxt = cnt;
    if (q.clr)                cnt_nxt = '0;
    else if (push_ok & ~pop_ok) cnt_nxt = cnt + CW'(1);
    else if (pop_ok & ~push_ok) cnt_nxt = cnt - CW'(1);
  end

  always_ff @(posedge ck or negedge rst_n) begin
    if (!rst_n) begin
      rd_pt <= '0;
      wr_pt <= '0;
      cnt   <= '0;
      ovf_r <= 1'b0;
      udf_r <= 1'b0;
    end else if (q.clr) begin
      rd_pt <= '0;
      wr_pt <= '0;
      cnt   <= '0;
      ovf_r <= 1'b0;
      udf_r <= 1'b0;
    end else begin
      if (push_ok) wr_pt <= PTBITS'(ptr_inc(32'(wr_pt), PTBITS));
      if (pop_ok)  rd_pt <= PTBITS'(ptr_inc(32'(rd_pt), PTBITS));
      cnt <= cnt_nxt;
      if (q.ld & st.full) ovf_r <= 1'b1;
      if (q.pp & st.em)   udf_r <= 1'b1;
    end
  end

  queue_ram #(.PTBITS(PTBITS), .NBITS(NBITS)) u_ram (
    .ck (ck),
    .we (push_ok & ~q.clr),
    .wa (wr_pt),
    .wd (q.in),
    .ra (rd_pt),
    .rd (q.out)
  );

`ifdef QUEUE_PEAK_EN
  logic [CW-1:0] peak_r;
  always_ff @(posedge ck or negedge rst_n) begin
    if (!rst_n)                peak_r <= '0;
    else if (q.clr)            peak_r <= '0;
    else if (cnt_nxt > peak_r) peak_r <= cnt_nxt;
  end
  assign q.peak = peak_r;
`else
  assign q.peak = '0;
`endif

  assign q.em           = st.em;
  assign q.full         = st.full;
  assign q.almost_full  = st.almost_full;
  assign q.almost_empty = st.almost_empty;
  assign q.ovf          = st.ovf;
  assign q.udf          = st.udf;
  assign q.count        = cnt;
endmodule

// File: tb/tb_stream_queue.sv
// Scoreboarded random/directed bench for stream_queue against a queue-based model.
module tb_stream_queue;
  localparam int PTBITS = 6;
  localparam int NBITS  = 8;
  localparam int DEPTH  = 64;
  localparam int AF     = 48;
  localparam int AE     = 8;

  typedef struct {
    int  cnt;
    bit  ovf;
    bit  udf;
    int  head;
    int  peak;
  } snap_t;

  logic ck = 1'b0;
  logic rst_n = 1'b0;
  always #5 ck = ~ck;

  stream_queue_if #(.PTBITS(PTBITS), .NBITS(NBITS)) qi ();

  stream_queue #(.PTBITS(PTBITS), .NBITS(NBITS), .AF_LEVEL(AF), .AE_LEVEL(AE)) dut (
    .ck    (ck),
    .rst_n (rst_n),
    .q     (qi)
  );

  int    errors = 0;
  int    checks = 0;
  snap_t exp_q[$];
  int    mq[$];
  bit    movf, mudf;
  int    mpeak;

  function automatic void check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endfunction

  function automatic void model_reset();
    mq.delete();
    movf = 0;
    mudf = 0;
    mpeak = 0;
  endfunction

  // Issue one cycle of stimulus; the model advances at the edge and queues its expectation.
  task automatic step(input bit l, input bit p, input int d, input bit c);
    snap_t s;
    bit was_full, was_em;
    qi.ld = l; qi.pp = p; qi.in = NBITS'(d); qi.clr = c;
    @(posedge ck);
    if (c) model_reset();
    else begin
      was_full = (mq.size() == DEPTH);
      was_em   = (mq.size() == 0);
      if (l && was_full) movf = 1;
      if (p && was_em)   mudf = 1;
      if (p && !was_em)  void'(mq.pop_front());
      if (l && !was_full) mq.push_back(d & 8'hFF);
`ifdef QUEUE_PEAK_EN
      if (mq.size() > mpeak) mpeak = mq.size();
`endif
    end
    s.cnt = mq.size();
    s.ovf = movf;
    s.udf = mudf;
    s.head = (mq.size() > 0) ? mq[0] : 0;
    s.peak = mpeak;
    exp_q.push_back(s);
    @(negedge ck);
    qi.ld = 0; qi.pp = 0; qi.clr = 0;
  endtask

  always @(negedge ck) begin
    snap_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("count", int'(qi.count), e.cnt);
      check("em", int'(qi.em), int'(e.cnt == 0));
      check("full", int'(qi.full), int'(e.cnt == DEPTH));
      check("almost_full", int'(qi.almost_full), int'(e.cnt >= AF));
      check("almost_empty", int'(qi.almost_empty), int'(e.cnt <= AE));
      check("ovf", int'(qi.ovf), int'(e.ovf));
      check("udf", int'(qi.udf), int'(e.udf));
      check("peak", int'(qi.peak), e.peak);
      if (e.cnt > 0) check("out", int'(qi.out), e.head);
    end
  end

  task automatic check_reset_state(input string tag);
    check({tag, "_em"}, int'(qi.em), 1);
    check({tag, "_count"}, int'(qi.count), 0);
    check({tag, "_full"}, int'(qi.full), 0);
    check({tag, "_ae"}, int'(qi.almost_empty), 1);
    check({tag, "_af"}, int'(qi.almost_full), 0);
    check({tag, "_ovf"}, int'(qi.ovf), 0);
    check({tag, "_udf"}, int'(qi.udf), 0);
    check({tag, "_peak"}, int'(qi.peak), 0);
  endtask

  initial begin
    int pat;
    qi.ld = 0; qi.pp = 0; qi.in = '0; qi.clr = 0;
    model_reset();
    #12;
    check_reset_state("reset");
    @(negedge ck); #2 rst_n = 1'b1;
    @(negedge ck);

    // fill, overflow, drain
    for (int i = 0; i < DEPTH; i++) step(1, 0, i, 0);
    step(1, 0, 8'hAA, 0);
    for (int i = 0; i < DEPTH; i++) step(0, 1, 0, 0);
    for (int i = 0; i < 5; i++) step(1, 0, 8'h10 + i, 0);
    step(0, 0, 0, 1);

    // pop on empty with simultaneous push
    step(1, 1, 8'h55, 0);
    step(0, 0, 0, 0);
    step(0, 1, 0, 0);

    // steady streaming across pointer wrap
    pat = 0;
    for (int i = 0; i < 10; i++) begin step(1, 0, pat, 0); pat++; end
    for (int i = 0; i < 200; i++) begin step(1, 1, pat, 0); pat++; end

    // async reset between edges at count=20
    for (int i = 0; i < 10; i++) begin step(1, 0, pat, 0); pat++; end
    #2 rst_n = 1'b0;
    #1;
    check_reset_state("async_rst");
    model_reset();
    @(negedge ck); #2 rst_n = 1'b1;
    @(negedge ck);
    step(1, 0, 8'h3C, 0);
    step(0, 0, 0, 0);
    step(0, 1, 0, 0);

    // peak tracking
    for (int i = 0; i < 30; i++) step(1, 0, i + 100, 0);
    for (int i = 0; i < 25; i++) step(0, 1, 0, 0);
    for (int i = 0; i < 10; i++) step(1, 0, i + 200, 0);
    step(0, 0, 0, 1);

    // random traffic with drifting push/pop bias
    for (int i = 0; i < 1500; i++) begin
      int bias;
      bias = ((i / 150) % 2 == 0) ? 70 : 30;
      step($urandom_range(99, 0) < bias, $urandom_range(99, 0) < (100 - bias),
           int'($urandom_range(255, 0)), $urandom_range(299, 0) == 0);
    end

    @(posedge ck); #1;
    check("scoreboard_drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/stream_queue.md
Name: stream_queue

Overview:
Parametrised successor to the single-clock sample queue used between the acquisition front-end and the host transmit path. It adds the following over the previous queue:
- full use of all 2**PTBITS entries;
- full, almost-full and almost-empty flags;
- an occupancy count;
- sticky overflow and underflow error flags;
- a synchronous flush.

It uses a show-ahead read: the head word is always presented on out while the queue is not empty.

Parameters:
PTBITS, 6, address width; DEPTH = 2**PTBITS entries (64)
NBITS, 8, data word width
AF_LEVEL, 48, almost_full asserted when count >= AF_LEVEL (legal range 1..DEPTH)
AE_LEVEL, 8, almost_empty asserted when count <= AE_LEVEL (legal range 0..DEPTH-1)

Ports:
ck  in  1  clock; all state updates on rising edge
rst_n  in  1  reset, asynchronous, active-low
clr  in  1  synchronous flush; clears pointers, count and error flags
in  in  NBITS  write data
ld  in  1  push request
pp  in  1  pop request; the head word is consumed at the edge
out  out  NBITS  head word (show-ahead); defined only while em=0
em  out  1  queue empty (count==0)
full  out  1  queue full (count==DEPTH)
almost_full  out  1  count >= AF_LEVEL
almost_empty  out  1  count <= AE_LEVEL
count  out  PTBITS+1  current occupancy, 0..DEPTH
ovf  out  1  sticky: a push was attempted while full
udf  out  1  sticky: a pop was attempted while empty
peak  out  PTBITS+1  maximum occupancy since reset/clr (see Optional Feature)

Behaviour:
- Reset (rst_n=0, async):
  - read pointer, write pointer, count, ovf, udf and peak go to 0.
  - em=1, full=0, almost_empty=1, almost_full=0.
  - Memory contents are not reset.
- clr=1 at an edge: same effect as reset, synchronously. It has priority over ld and pp in the same cycle, so those are ignored.
- Push accepted = ld & ~full, where full is the registered-state value before the edge.
  - On accept, mem[wr_pt] <= in and wr_pt increments modulo DEPTH (wrap from DEPTH-1 to 0).
- Pop accepted = pp & ~em.
  - On accept, rd_pt increments modulo DEPTH.
- Push while full: the word is dropped, state is unchanged, ovf <= 1. A pop in the same cycle is still honoured, but the push is not retried.
- Pop while empty: ignored, udf <= 1. A push in the same cycle is still honoured.
- Simultaneous accepted push and pop: count unchanged and both pointers advance. This is legal at any 0 < count < DEPTH.
- Count update: +1 on push-only, -1 on pop-only, otherwise unchanged.
- Flags: em, full, almost_full and almost_empty are derived combinationally from the registered count. They are valid in the cycle after the updating edge, with 0-cycle latency from count.
- out = mem[rd_pt], read combinationally (asynchronous memory read).
  - First-word latency: a word pushed into an empty queue appears on out, with em=0, after one edge.
- ovf and udf stay set until rst_n or clr.

Optional Feature:
Macro QUEUE_PEAK_EN.
- Defined: peak register of width PTBITS+1. It updates to the next count whenever the next count > peak, and is cleared by rst_n or clr.
- Undefined: peak is tied to 0 and no register is inferred. The port is kept so the interface is stable.

Decomposition:
- Package queue_pkg holds:
  - a count-width helper constant/function (PTBITS+1);
  - a pointer-increment function with modulo wrap;
  - a queue_status struct grouping em, full, almost_full, almost_empty, ovf, udf, for the status register map.
- One sub-module, queue_ram: a DEPTH x NBITS simple dual-port memory with a synchronous write port and an asynchronous read port.
- Pointer, count and flag logic stays in stream_queue.

Test Plan:
1. Fill and drain: after reset push 0x00..0x3F on 64 consecutive cycles.
   - Expect full=1, count=64, almost_full from count=48, and no ovf.
   - Pop 64 times: out sequence 0x00..0x3F, then em=1 and almost_empty from count=8.
2. Overflow: with the queue full, push 0xAA.
   - Expect ovf=1, count stays 64, and 0xAA never appears on out.
   - A following clr gives ovf=0, count=0, em=1.
3. Underflow plus simultaneous push: on an empty queue, ld=1, pp=1, in=0x55.
   - Expect udf=1, count=1, out=0x55 on the next cycle.
4. Wrap-around streaming: hold count at 10 while doing simultaneous push/pop for 200 cycles with an incrementing pattern.
   - Expect count constant at 10 and out strictly in push order across the pointer wrap.
5. Async reset mid-stream: assert rst_n=0 between edges with count=20.
   - Expect em=1, count=0, ovf=udf=0 immediately, without waiting for an edge.
   - After release, the first push is read back correctly.
6. With QUEUE_PEAK_EN: push 30, pop 25, push 10.
   - Expect peak=30 then 30, with count=15.
   - After clr, peak=0.
